// File: rtl/l2_mem_arbiter_if.sv
// rtl/l2_mem_arbiter_if.sv - L2-side and memory-side TileLink-UL A/D channel bundle for l2_mem_arbiter
interface l2_mem_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int OP_W      = 3,
  parameter int SIZE_W    = 3,
  parameter int SRC_W     = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MASK_W    = 8
);
  localparam int PORT_W  = $clog2(NUM_PORTS);
  localparam int PARAM_W = 3;

  logic [NUM_PORTS-1:0]         in_a_valid;
  logic [NUM_PORTS-1:0]         in_a_ready;
  logic [NUM_PORTS*OP_W-1:0]    in_a_opcode;
  logic [NUM_PORTS*SIZE_W-1:0]  in_a_size;
  logic [NUM_PORTS*SRC_W-1:0]   in_a_source;
  logic [NUM_PORTS*ADDR_W-1:0]  in_a_address;
  logic [NUM_PORTS*MASK_W-1:0]  in_a_mask;
  logic [NUM_PORTS*DATA_W-1:0]  in_a_data;
  logic [NUM_PORTS*PARAM_W-1:0] in_a_param;

  logic [NUM_PORTS-1:0]         in_d_valid;
  logic [NUM_PORTS-1:0]         in_d_ready;
  logic [NUM_PORTS*OP_W-1:0]    in_d_opcode;
  logic [NUM_PORTS*SIZE_W-1:0]  in_d_size;
  logic [NUM_PORTS*SRC_W-1:0]   in_d_source;
  logic [NUM_PORTS*DATA_W-1:0]  in_d_data;
  logic [NUM_PORTS*PARAM_W-1:0] in_d_param;

  logic                         mem_a_valid;
  logic                         mem_a_ready;
  logic [OP_W-1:0]              mem_a_opcode;
  logic [SIZE_W-1:0]            mem_a_size;
  logic [PORT_W+SRC_W-1:0]      mem_a_source;
  logic [ADDR_W-1:0]            mem_a_address;
  logic [MASK_W-1:0]            mem_a_mask;
  logic [DATA_W-1:0]            mem_a_data;
  logic [PARAM_W-1:0]           mem_a_param;

  logic                         mem_d_valid;
  logic                         mem_d_ready;
  logic [OP_W-1:0]              mem_d_opcode;
  logic [SIZE_W-1:0]            mem_d_size;
  logic [PORT_W+SRC_W-1:0]      mem_d_source;
  logic [DATA_W-1:0]            mem_d_data;
  logic [PARAM_W-1:0]           mem_d_param;

  // The arbiter is the slave of the L2 A channels and the master of the memory A channel.
  modport slave (
    input  in_a_valid, in_a_opcode, in_a_size, in_a_source, in_a_address, in_a_mask, in_a_data, in_a_param,
    output in_a_ready,
    output in_d_valid, in_d_opcode, in_d_size, in_d_source, in_d_data, in_d_param,
    input  in_d_ready,
    output mem_a_valid, mem_a_opcode, mem_a_size, mem_a_source, mem_a_address, mem_a_mask, mem_a_data, mem_a_param,
    input  mem_a_ready,
    input  mem_d_valid, mem_d_opcode, mem_d_size, mem_d_source, mem_d_data, mem_d_param,
    output mem_d_ready
  );

  modport master (
    output in_a_valid, in_a_opcode, in_a_size, in_a_source, in_a_address, in_a_mask, in_a_data, in_a_param,
    input  in_a_ready,
    input  in_d_valid, in_d_opcode, in_d_size, in_d_source, in_d_data, in_d_param,
    output in_d_ready,
    input  mem_a_valid, mem_a_opcode, mem_a_size, mem_a_source, mem_a_address, mem_a_mask, mem_a_data, mem_a_param,
    output mem_a_ready,
    output mem_d_valid, mem_d_opcode, mem_d_size, mem_d_source, mem_d_data, mem_d_param,
    input  mem_d_ready
  );
endinterface

// File: rtl/l2_mem_arbiter.sv
// rtl/l2_mem_arbiter.sv - round-robin merge of L2 A channels onto one memory port, tagged D routing back
// Optional performance counters are built when L2ARB_PERF_CNT_EN is defined.
module l2_mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int OP_W      = 3,
  parameter int SIZE_W    = 3,
  parameter int SRC_W     = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MASK_W    = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic            clk,
  input  logic            rstn,
  l2_mem_arbiter_if.slave bus,
  output logic            err_sticky
`ifdef L2ARB_PERF_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0] perf_grant_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);
  localparam int PORT_W  = $clog2(NUM_PORTS);
  localparam int CNT_W   = $clog2(MAX_OUTST + 1);
  localparam int PARAM_W = 3;

  logic                 rst_meta;
  logic                 rst_n;
  logic [PORT_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]     outst [NUM_PORTS];
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] a_fire;
  logic [NUM_PORTS-1:0] d_fire;
  logic                 slot_free;
  logic                 grant_vld;
  logic [PORT_W-1:0]    grant_idx;
  logic [PORT_W-1:0]    d_tag;
  logic                 bad_tag;

  // Assertion is immediate; release passes through two flops so every state flop leaves reset on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  assign slot_free = !bus.mem_a_valid || bus.mem_a_ready;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      eligible[i] = bus.in_a_valid[i] && (outst[i] < CNT_W'(MAX_OUTST));
  end

  // Walk from the farthest candidate back to rr_ptr so the nearest eligible port is written last.
  always_comb begin
    int p;
    grant_vld = 1'b0;
    grant_idx = '0;
    p         = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      p = int'(rr_ptr) + k;
      if (p >= NUM_PORTS)
        p = p - NUM_PORTS;
      if (eligible[PORT_W'(p)]) begin
        grant_vld = 1'b1;
        grant_idx = PORT_W'(p);
      end
    end
  end

  always_comb begin
    bus.in_a_ready = '0;
    if (rst_n && slot_free && grant_vld)
      bus.in_a_ready[grant_idx] = 1'b1;
  end

  assign a_fire = bus.in_a_valid & bus.in_a_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_a_valid   <= 1'b0;
      bus.mem_a_opcode  <= '0;
      bus.mem_a_size    <= '0;
      bus.mem_a_source  <= '0;
      bus.mem_a_address <= '0;
      bus.mem_a_mask    <= '0;
      bus.mem_a_data    <= '0;
      bus.mem_a_param   <= '0;
      rr_ptr            <= '0;
    end else if (slot_free) begin
      if (grant_vld) begin
        bus.mem_a_valid   <= 1'b1;
        bus.mem_a_opcode  <= bus.in_a_opcode[grant_idx*OP_W +: OP_W];
        bus.mem_a_size    <= bus.in_a_size[grant_idx*SIZE_W +: SIZE_W];
        bus.mem_a_source  <= {grant_idx, bus.in_a_source[grant_idx*SRC_W +: SRC_W]};
        bus.mem_a_address <= bus.in_a_address[grant_idx*ADDR_W +: ADDR_W];
        bus.mem_a_mask    <= bus.in_a_mask[grant_idx*MASK_W +: MASK_W];
        bus.mem_a_data    <= bus.in_a_data[grant_idx*DATA_W +: DATA_W];
        bus.mem_a_param   <= bus.in_a_param[grant_idx*PARAM_W +: PARAM_W];
        rr_ptr            <= (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
      end else begin
        bus.mem_a_valid <= 1'b0;
      end
    end
  end

  assign d_tag   = bus.mem_d_source[SRC_W +: PORT_W];
  assign bad_tag = int'(d_tag) >= NUM_PORTS;

  // A response carrying an unknown tag is swallowed so it cannot stall the memory D channel.
  always_comb begin
    bus.in_d_valid  = '0;
    bus.mem_d_ready = bad_tag;
    d_fire          = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!bad_tag && d_tag == PORT_W'(i)) begin
        bus.in_d_valid[i] = rst_n && bus.mem_d_valid;
        bus.mem_d_ready   = bus.in_d_ready[i];
        d_fire[i]         = bus.mem_d_valid && bus.in_d_ready[i];
      end
    end
  end

  assign bus.in_d_opcode = {NUM_PORTS{bus.mem_d_opcode}};
  assign bus.in_d_size   = {NUM_PORTS{bus.mem_d_size}};
  assign bus.in_d_source = {NUM_PORTS{bus.mem_d_source[SRC_W-1:0]}};
  assign bus.in_d_data   = {NUM_PORTS{bus.mem_d_data}};
  assign bus.in_d_param  = {NUM_PORTS{bus.mem_d_param}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++)
        outst[i] <= '0;
      err_sticky <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (a_fire[i] && !d_fire[i])
          outst[i] <= outst[i] + 1'b1;
        else if (d_fire[i] && !a_fire[i] && outst[i] != '0)
          outst[i] <= outst[i] - 1'b1;
        if (d_fire[i] && outst[i] == '0)
          err_sticky <= 1'b1;
      end
      if (bus.mem_d_valid && bad_tag)
        err_sticky <= 1'b1;
    end
  end

`ifdef L2ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (a_fire[i] && perf_grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)
          perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
      end
      if (bus.mem_a_valid && !bus.mem_a_ready && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb/tb_l2_mem_arbiter.sv - directed and randomized self-checking bench for l2_mem_arbiter
module tb_l2_mem_arbiter;
  localparam int NP        = 3;
  localparam int OP_W      = 3;
  localparam int SIZE_W    = 3;
  localparam int SRC_W     = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MASK_W    = 4;
  localparam int MAX_OUTST = 4;
  localparam int PORT_W    = 2;
  localparam int BEAT_W    = OP_W + SIZE_W + PORT_W + SRC_W + ADDR_W + MASK_W + DATA_W + 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic err_sticky;
`ifdef L2ARB_PERF_CNT_EN
  logic [NP*32-1:0] perf_grant_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  l2_mem_arbiter_if #(.NUM_PORTS(NP), .OP_W(OP_W), .SIZE_W(SIZE_W), .SRC_W(SRC_W),
                      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  l2_mem_arbiter #(.NUM_PORTS(NP), .OP_W(OP_W), .SIZE_W(SIZE_W), .SRC_W(SRC_W), .ADDR_W(ADDR_W),
                   .DATA_W(DATA_W), .MASK_W(MASK_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .err_sticky (err_sticky)
`ifdef L2ARB_PERF_CNT_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model: per-port outstanding counts, next round-robin start, the beat expected on memory A.
  int              m_outst[NP];
  int              m_rr;
  bit              m_err;
  bit              m_av;
  logic [BEAT_W-1:0] m_beat;
  logic [31:0]     m_gcnt[NP];
  logic [31:0]     m_stall;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_outst[p] = 0;
      m_gcnt[p]  = 0;
    end
    m_rr = 0; m_err = 0; m_av = 0; m_beat = '0; m_stall = 0;
  endtask

  function automatic logic [BEAT_W-1:0] in_beat(input int p);
    return {bus.in_a_opcode[p*OP_W +: OP_W], bus.in_a_size[p*SIZE_W +: SIZE_W],
            PORT_W'(p), bus.in_a_source[p*SRC_W +: SRC_W], bus.in_a_address[p*ADDR_W +: ADDR_W],
            bus.in_a_mask[p*MASK_W +: MASK_W], bus.in_a_data[p*DATA_W +: DATA_W], bus.in_a_param[p*3 +: 3]};
  endfunction

  function automatic logic [BEAT_W-1:0] dut_beat();
    return {bus.mem_a_opcode, bus.mem_a_size, bus.mem_a_source, bus.mem_a_address,
            bus.mem_a_mask, bus.mem_a_data, bus.mem_a_param};
  endfunction

  task automatic set_a(input int p, input logic [31:0] op, input logic [31:0] addr, input logic [31:0] src,
                       input logic [31:0] misc);
    bus.in_a_opcode[p*OP_W +: OP_W]     = op[OP_W-1:0];
    bus.in_a_address[p*ADDR_W +: ADDR_W] = addr;
    bus.in_a_source[p*SRC_W +: SRC_W]   = src[SRC_W-1:0];
    bus.in_a_size[p*SIZE_W +: SIZE_W]   = misc[2:0];
    bus.in_a_mask[p*MASK_W +: MASK_W]   = misc[7:4];
    bus.in_a_param[p*3 +: 3]            = misc[10:8];
    bus.in_a_data[p*DATA_W +: DATA_W]   = misc ^ addr;
  endtask

  task automatic idle_inputs();
    bus.in_a_valid = '0; bus.in_a_opcode = '0; bus.in_a_size = '0; bus.in_a_source = '0;
    bus.in_a_address = '0; bus.in_a_mask = '0; bus.in_a_data = '0; bus.in_a_param = '0;
    bus.in_d_ready = '1; bus.mem_a_ready = 1'b1;
    bus.mem_d_valid = 1'b0; bus.mem_d_opcode = '0; bus.mem_d_size = '0;
    bus.mem_d_source = '0; bus.mem_d_data = '0; bus.mem_d_param = '0;
  endtask

  // Check every output against the model for the current inputs, then step the model and the clock.
  task automatic cycle();
    int g, t, p;
    bit sf, bad, dfire, exp_dready;
    logic [NP-1:0] exp_dv;
    #1;
    chk("mem_a_valid", bus.mem_a_valid, m_av);
    if (m_av) chk("mem_a_beat", dut_beat(), m_beat);
    chk("err_sticky", err_sticky, m_err);
    sf = !m_av || bus.mem_a_ready;
    g = -1;
    if (sf) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_rr + k) % NP;
        if (g < 0 && bus.in_a_valid[p] && m_outst[p] < MAX_OUTST) g = p;
      end
    end
    chk("in_a_ready", bus.in_a_ready, (g >= 0) ? (1 << g) : 0);
    t = int'(bus.mem_d_source) >> SRC_W;
    bad = (t >= NP);
    exp_dv = (bus.mem_d_valid && !bad) ? NP'(1 << t) : '0;
    exp_dready = bad ? 1'b1 : bus.in_d_ready[t];
    chk("in_d_valid", bus.in_d_valid, exp_dv);
    chk("mem_d_ready", bus.mem_d_ready, exp_dready);
    chk("in_d_source", bus.in_d_source, {NP{bus.mem_d_source[SRC_W-1:0]}});
    chk("in_d_data", bus.in_d_data, {NP{bus.mem_d_data}});
`ifdef L2ARB_PERF_CNT_EN
    for (int q = 0; q < NP; q++) chk("perf_grant", perf_grant_cnt[q*32 +: 32], m_gcnt[q]);
    chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    dfire = bus.mem_d_valid && exp_dready && !bad;
    if (bus.mem_d_valid && bad) m_err = 1;
    if (dfire && m_outst[t] == 0) m_err = 1;
    if (m_av && !bus.mem_a_ready) m_stall++;
    if (sf) begin
      if (g >= 0) begin
        m_beat = in_beat(g);
        m_av = 1;
        m_rr = (g + 1) % NP;
        m_gcnt[g]++;
      end else begin
        m_av = 0;
      end
    end
    if (g >= 0) m_outst[g]++;
    if (dfire) m_outst[t] = (m_outst[t] > 0) ? m_outst[t] - 1 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic d_resp(input int p, input int s);
    bus.mem_d_valid  = 1'b1;
    bus.mem_d_source = {PORT_W'(p), SRC_W'(s)};
    bus.mem_d_opcode = OP_W'(1);
    bus.mem_d_data   = $urandom;
    cycle();
    bus.mem_d_valid = 1'b0;
  endtask

  task automatic drain_all();
    bus.in_a_valid = '0;
    bus.in_d_ready = '1;
    for (int p = 0; p < NP; p++)
      repeat (m_outst[p]) d_resp(p, 0);
  endtask

  task automatic release_reset();
    idle_inputs();
    model_reset();
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int grants;
    logic [BEAT_W-1:0] held;
`ifdef L2ARB_PERF_CNT_EN
    logic [31:0] stall0;
`endif
    idle_inputs();
    model_reset();
    bus.in_a_valid  = '1;
    bus.mem_d_valid = 1'b1;
    #3;
    chk("rst_mem_a_valid", bus.mem_a_valid, 1'b0);
    chk("rst_in_a_ready", bus.in_a_ready, 3'b000);
    chk("rst_in_d_valid", bus.in_d_valid, 3'b000);
    chk("rst_err", err_sticky, 1'b0);
    chk("rst_a_fields", dut_beat(), '0);
    repeat (2) @(posedge clk);
    #1;
    release_reset();

    // Single read from port 1
    set_a(1, 4, 32'h9000_0000, 3, 0);
    bus.in_a_valid = 3'b010;
    #1 chk("single_grant", bus.in_a_ready, 3'b010);
    cycle();
    bus.in_a_valid = '0;
    chk("single_valid", bus.mem_a_valid, 1'b1);
    chk("single_source", bus.mem_a_source, 6'h13);
    chk("single_addr", bus.mem_a_address, 32'h9000_0000);
    chk("single_op", bus.mem_a_opcode, 3'd4);
    cycle();
    bus.mem_d_valid  = 1'b1;
    bus.mem_d_source = 6'h13;
    #1 chk("single_d_valid", bus.in_d_valid, 3'b010);
    chk("single_d_src", bus.in_d_source[2*SRC_W-1:SRC_W], 4'd3);
    cycle();
    bus.mem_d_valid = 1'b0;

    // Two-way contention alternates
    set_a(0, 4, 32'h100, 1, 5);
    set_a(1, 1, 32'h200, 2, 6);
    bus.in_a_valid = 3'b011;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_grant", bus.in_a_ready, (k % 2 == 0) ? 3'b001 : 3'b010);
      cycle();
    end
    bus.in_a_valid = '0;
    cycle();
    drain_all();

    // Backpressure holds the beat
    set_a(2, 0, 32'hABCD_0000, 7, 32'h5A5);
    bus.in_a_valid = 3'b100;
    cycle();
    bus.in_a_valid = 3'b001;
    bus.mem_a_ready = 1'b0;
    held = dut_beat();
`ifdef L2ARB_PERF_CNT_EN
    stall0 = perf_stall_cnt;
`endif
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", bus.in_a_ready, 3'b000);
      cycle();
      chk("bp_hold", dut_beat(), held);
    end
`ifdef L2ARB_PERF_CNT_EN
    chk("bp_stall_cnt", perf_stall_cnt - stall0, 32'd5);
`endif
    bus.mem_a_ready = 1'b1;
    cycle();
    bus.in_a_valid = '0;
    cycle();
    drain_all();

    // Outstanding limit on port 0
    bus.in_a_valid = 3'b001;
    repeat (4) cycle();
    #1 chk("limit_block", bus.in_a_ready, 3'b000);
    bus.in_a_valid = 3'b011;
    #1 chk("limit_other", bus.in_a_ready, 3'b010);
    cycle();
    bus.in_a_valid = 3'b001;
    d_resp(0, 9);
    #1 chk("limit_regrant", bus.in_a_ready, 3'b001);
    cycle();
    bus.in_a_valid = '0;
    cycle();
    drain_all();

    // Simultaneous A and D fire on port 0 at outst 2
    bus.in_a_valid = 3'b001;
    cycle();
    cycle();
    bus.mem_d_valid  = 1'b1;
    bus.mem_d_source = {2'd0, 4'd1};
    #1 chk("simul_grant", bus.in_a_ready, 3'b001);
    cycle();
    bus.mem_d_valid = 1'b0;
    grants = 0;
    for (int k = 0; k < 4; k++) begin
      #1 if (bus.in_a_ready[0]) grants++;
      cycle();
    end
    chk("simul_outst", grants, 2);
    bus.in_a_valid = '0;
    cycle();
    drain_all();

    // Bad tag and unexpected response
    chk("err_before", err_sticky, 1'b0);
    bus.in_d_ready   = '0;
    bus.mem_d_valid  = 1'b1;
    bus.mem_d_source = {2'd3, 4'd5};
    #1 chk("badtag_ready", bus.mem_d_ready, 1'b1);
    chk("badtag_no_dv", bus.in_d_valid, 3'b000);
    cycle();
    bus.mem_d_valid = 1'b0;
    chk("badtag_err", err_sticky, 1'b1);
    bus.in_d_ready   = '1;
    bus.mem_d_valid  = 1'b1;
    bus.mem_d_source = {2'd1, 4'd2};
    #1 chk("orphan_dv", bus.in_d_valid, 3'b010);
    cycle();
    bus.mem_d_valid = 1'b0;
    chk("orphan_err", err_sticky, 1'b1);

    // Reset in the middle of a stalled transfer
    bus.in_a_valid = 3'b001;
    repeat (4) cycle();
    bus.in_a_valid = 3'b010;
    cycle();
    bus.in_a_valid  = '0;
    bus.mem_a_ready = 1'b0;
    chk("mid_valid_pre", bus.mem_a_valid, 1'b1);
    #2 rstn = 1'b0;
    #1 chk("mid_rst_valid", bus.mem_a_valid, 1'b0);
    chk("mid_rst_err", err_sticky, 1'b0);
    @(posedge clk);
    #1;
    release_reset();
    bus.in_a_valid = 3'b001;
    #1 chk("mid_rst_outst", bus.in_a_ready, 3'b001);
    cycle();
    bus.in_a_valid = '0;
    cycle();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) set_a(p, $urandom, $urandom, $urandom, $urandom);
      bus.in_a_valid  = NP'($urandom);
      bus.mem_a_ready = ($urandom % 4) != 0;
      bus.in_d_ready  = NP'($urandom);
      if ($urandom % 3 == 0) begin
        bus.mem_d_valid  = 1'b1;
        bus.mem_d_source = {(($urandom % 16) == 0) ? 2'd3 : PORT_W'($urandom % NP), SRC_W'($urandom)};
        bus.mem_d_data   = $urandom;
        bus.mem_d_opcode = OP_W'($urandom);
      end else begin
        bus.mem_d_valid = 1'b0;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
